// File: rtl/ccm_rmw_controller.sv
// CCM controller for a 1R1W word-write SRAM: byte-strobed writes become a
// read-modify-write, and write data is forwarded to same-cycle reads.
module ccm_rmw_controller #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    cntlr_rd,
    input  logic [ADDR_WIDTH-1:0]   cntlr_raddr,
    output logic [DATA_WIDTH-1:0]   cntlr_rd_data,
    output logic                    cntlr_rd_valid,

    input  logic                    cntlr_wr,
    input  logic [ADDR_WIDTH-1:0]   cntlr_waddr,
    input  logic [DATA_WIDTH-1:0]   cntlr_wr_data,
    input  logic [DATA_WIDTH/8-1:0] cntlr_wr_strb,
    output logic                    cntlr_wr_ready,
    output logic                    rmw_busy,

    output logic                    mem_rd,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,
    output logic                    mem_wr,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [STRB_WIDTH-1:0]   strb_q;

    logic                    rd_vld1_q;
    logic                    fwd_hit_q;
    logic [DATA_WIDTH-1:0]   fwd_data_q;
    logic                    fwd_hit_d;

    logic                    strb_full;
    logic                    strb_null;
    logic                    strb_partial;
    logic                    wr_fire;
    logic                    rmw_start;
    logic [DATA_WIDTH-1:0]   merged;
    logic [DATA_WIDTH-1:0]   stage1_data;

    assign strb_full    = &cntlr_wr_strb;
    assign strb_null    = ~|cntlr_wr_strb;
    assign strb_partial = !strb_full && !strb_null;

    // The SRAM read port is shared: a pending read blocks a partial write.
    assign cntlr_wr_ready = (state_q == IDLE) && !(cntlr_rd && strb_partial);
    assign rmw_busy       = (state_q == RMW_WR);
    assign wr_fire        = cntlr_wr && cntlr_wr_ready;
    assign rmw_start      = wr_fire && strb_partial;

    always_comb begin
        merged = '0;
        for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
            merged[8*i +: 8] = strb_q[i] ? data_q[8*i +: 8] : mem_rd_data[8*i +: 8];
        end
    end

    always_comb begin
        mem_rd      = cntlr_rd || rmw_start;
        mem_rd_addr = cntlr_rd ? cntlr_raddr : cntlr_waddr;
        if (state_q == RMW_WR) begin
            mem_wr      = 1'b1;
            mem_wr_addr = addr_q;
            mem_wr_data = merged;
        end else begin
            mem_wr      = wr_fire && strb_full;
            mem_wr_addr = cntlr_waddr;
            mem_wr_data = cntlr_wr_data;
        end
    end

    assign fwd_hit_d = cntlr_rd && mem_wr && (cntlr_raddr == mem_wr_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rmw_start) begin
                        state_q <= RMW_WR;
                        addr_q  <= cntlr_waddr;
                        data_q  <= cntlr_wr_data;
                        strb_q  <= cntlr_wr_strb;
                    end
                end
                RMW_WR: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // SRAM is read-first, so a read colliding with a write returns the new word from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld1_q  <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            rd_vld1_q <= cntlr_rd;
            fwd_hit_q <= fwd_hit_d;
            if (fwd_hit_d) begin
                fwd_data_q <= mem_wr_data;
            end
        end
    end

    assign stage1_data = fwd_hit_q ? fwd_data_q : mem_rd_data;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  rd_vld2_q;
            logic [DATA_WIDTH-1:0] rd_data2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_vld2_q  <= 1'b0;
                    rd_data2_q <= '0;
                end else begin
                    rd_vld2_q <= rd_vld1_q;
                    if (rd_vld1_q) begin
                        rd_data2_q <= stage1_data;
                    end
                end
            end

            assign cntlr_rd_valid = rd_vld2_q;
            assign cntlr_rd_data  = rd_data2_q;
        end else begin : g_no_out_reg
            assign cntlr_rd_valid = rd_vld1_q;
            assign cntlr_rd_data  = stage1_data;
        end
    endgenerate

endmodule

// File: tb/tb_ccm_rmw_controller.sv
// Directed bench: OUT_REG=0 and OUT_REG=1 instances driven in lockstep,
// each against its own read-first 1R1W SRAM model.
module tb_ccm_rmw_controller;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          preload;
    logic          rd;
    logic [AW-1:0] raddr;
    logic          wr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [3:0]    strb;

    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1;
    logic          wr_ready0, wr_ready1;
    logic          busy0, busy1;
    logic          m0_rd, m1_rd, m0_wr, m1_wr;
    logic [AW-1:0] m0_rd_addr, m1_rd_addr, m0_wr_addr, m1_wr_addr;
    logic [DW-1:0] m0_rd_data, m1_rd_data, m0_wr_data, m1_wr_data;

    logic [DW-1:0] mem0 [0:2047];
    logic [DW-1:0] mem1 [0:2047];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ccm_rmw_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cntlr_rd(rd), .cntlr_raddr(raddr),
        .cntlr_rd_data(rd_data0), .cntlr_rd_valid(rd_valid0),
        .cntlr_wr(wr), .cntlr_waddr(waddr), .cntlr_wr_data(wdata),
        .cntlr_wr_strb(strb), .cntlr_wr_ready(wr_ready0), .rmw_busy(busy0),
        .mem_rd(m0_rd), .mem_rd_addr(m0_rd_addr), .mem_rd_data(m0_rd_data),
        .mem_wr(m0_wr), .mem_wr_addr(m0_wr_addr), .mem_wr_data(m0_wr_data)
    );

    ccm_rmw_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cntlr_rd(rd), .cntlr_raddr(raddr),
        .cntlr_rd_data(rd_data1), .cntlr_rd_valid(rd_valid1),
        .cntlr_wr(wr), .cntlr_waddr(waddr), .cntlr_wr_data(wdata),
        .cntlr_wr_strb(strb), .cntlr_wr_ready(wr_ready1), .rmw_busy(busy1),
        .mem_rd(m1_rd), .mem_rd_addr(m1_rd_addr), .mem_rd_data(m1_rd_data),
        .mem_wr(m1_wr), .mem_wr_addr(m1_wr_addr), .mem_wr_data(m1_wr_data)
    );

    // Read-first synchronous SRAM models.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2048; i++) begin
                mem0[i] <= '0;
                mem1[i] <= '0;
            end
            mem0[7]  <= 32'h11223344; mem1[7]  <= 32'h11223344;
            mem0[9]  <= 32'h99999999; mem1[9]  <= 32'h99999999;
            mem0[12] <= 32'h12121212; mem1[12] <= 32'h12121212;
            m0_rd_data <= '0;
            m1_rd_data <= '0;
        end else begin
            if (m0_rd) m0_rd_data <= mem0[m0_rd_addr];
            if (m0_wr) mem0[m0_wr_addr] <= m0_wr_data;
            if (m1_rd) m1_rd_data <= mem1[m1_rd_addr];
            if (m1_wr) mem1[m1_wr_addr] <= m1_wr_data;
        end
    end

    typedef struct {
        logic          rd;
        logic [AW-1:0] raddr;
        logic          wr;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [3:0]    strb;
        logic          e_ready;
        logic          e_busy;
        logic          e_mrd;
        logic [AW-1:0] e_mrd_addr;
        logic          e_mwr;
        logic [AW-1:0] e_mwr_addr;
        logic [DW-1:0] e_mwr_data;
        logic          e_vld;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic [AW-1:0] ra,
        input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [3:0] s,
        input logic ery, input logic eb,
        input logic emr, input logic [AW-1:0] emra,
        input logic emw, input logic [AW-1:0] emwa, input logic [DW-1:0] emwd,
        input logic ev, input logic [DW-1:0] erd);
        vec_t v;
        v.rd = r; v.raddr = ra; v.wr = w; v.waddr = wa; v.wdata = wd; v.strb = s;
        v.e_ready = ery; v.e_busy = eb; v.e_mrd = emr; v.e_mrd_addr = emra;
        v.e_mwr = emw; v.e_mwr_addr = emwa; v.e_mwr_data = emwd;
        v.e_vld = ev; v.e_rdata = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [AW-1:0] ra, input logic w,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [3:0] s);
        rd = r; raddr = ra; wr = w; waddr = wa; wdata = wd; strb = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic          prev_vld;
        logic [DW-1:0] prev_data;
        string         tag;

        rst_n   = 1'b1;
        preload = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0, '0);
        #1 rst_n = 1'b0;

        vecs.push_back(mk(0,0,  0,0,0,4'h0,                  1,0, 0,0, 0,0,0,                   0,0));
        vecs.push_back(mk(0,0,  1,5,32'hDEADBEEF,4'hF,       1,0, 0,0, 1,5,32'hDEADBEEF,        0,0));
        vecs.push_back(mk(0,0,  0,0,0,4'h0,                  1,0, 0,0, 0,0,0,                   0,0));
        vecs.push_back(mk(1,5,  0,0,0,4'h0,                  1,0, 1,5, 0,0,0,                   0,0));
        vecs.push_back(mk(0,0,  0,0,0,4'h0,                  1,0, 0,0, 0,0,0,                   1,32'hDEADBEEF));
        vecs.push_back(mk(0,0,  1,7,32'hAABBCCDD,4'h5,       1,0, 1,7, 0,0,0,                   0,0));
        vecs.push_back(mk(1,7,  0,0,0,4'h0,                  0,1, 1,7, 1,7,32'h11BB33DD,        0,0));
        vecs.push_back(mk(0,0,  0,0,0,4'h0,                  1,0, 0,0, 0,0,0,                   1,32'h11BB33DD));
        vecs.push_back(mk(1,3,  1,3,32'hCAFEF00D,4'hF,       1,0, 1,3, 1,3,32'hCAFEF00D,        0,0));
        vecs.push_back(mk(0,0,  0,0,0,4'h0,                  1,0, 0,0, 0,0,0,                   1,32'hCAFEF00D));
        vecs.push_back(mk(1,3,  1,7,32'h55000000,4'h8,       0,0, 1,3, 0,0,0,                   0,0));
        vecs.push_back(mk(0,0,  1,7,32'h55000000,4'h8,       1,0, 1,7, 0,0,0,                   1,32'hCAFEF00D));
        vecs.push_back(mk(0,0,  1,4,32'h44444444,4'hF,       0,1, 0,0, 1,7,32'h55BB33DD,        0,0));
        vecs.push_back(mk(1,7,  0,0,0,4'h0,                  1,0, 1,7, 0,0,0,                   0,0));
        vecs.push_back(mk(1,4,  0,0,0,4'h0,                  1,0, 1,4, 0,0,0,                   1,32'h55BB33DD));
        vecs.push_back(mk(0,0,  1,9,32'hFFFFFFFF,4'h0,       1,0, 0,0, 0,0,0,                   1,32'h00000000));
        vecs.push_back(mk(1,9,  1,9,32'hFFFFFFFF,4'h0,       1,0, 1,9, 0,0,0,                   0,0));
        vecs.push_back(mk(1,5,  1,10,32'h0A0A0A0A,4'hF,      1,0, 1,5, 1,10,32'h0A0A0A0A,       1,32'h99999999));
        vecs.push_back(mk(0,0,  0,0,0,4'h0,                  1,0, 0,0, 0,0,0,                   1,32'hDEADBEEF));
        vecs.push_back(mk(0,0,  0,0,0,4'h0,                  1,0, 0,0, 0,0,0,                   0,0));

        @(negedge clk);
        preload = 1'b0;
        #1;
        chk("reset wr_ready", {31'd0, wr_ready0}, 32'd1);
        chk("reset rmw_busy", {31'd0, busy0}, 32'd0);
        chk("reset rd_valid", {31'd0, rd_valid0}, 32'd0);
        chk("reset rd_valid outreg", {31'd0, rd_valid1}, 32'd0);
        chk("reset rd_data outreg", rd_data1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        prev_vld  = 1'b0;
        prev_data = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rd, vecs[i].raddr, vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].strb);
            #1;
            tag = $sformatf("v%0d", i);
            chk({tag, " wr_ready"}, {31'd0, wr_ready0}, {31'd0, vecs[i].e_ready});
            chk({tag, " rmw_busy"}, {31'd0, busy0}, {31'd0, vecs[i].e_busy});
            chk({tag, " mem_rd"}, {31'd0, m0_rd}, {31'd0, vecs[i].e_mrd});
            if (vecs[i].e_mrd)
                chk({tag, " mem_rd_addr"}, {21'd0, m0_rd_addr}, {21'd0, vecs[i].e_mrd_addr});
            chk({tag, " mem_wr"}, {31'd0, m0_wr}, {31'd0, vecs[i].e_mwr});
            if (vecs[i].e_mwr) begin
                chk({tag, " mem_wr_addr"}, {21'd0, m0_wr_addr}, {21'd0, vecs[i].e_mwr_addr});
                chk({tag, " mem_wr_data"}, m0_wr_data, vecs[i].e_mwr_data);
            end
            chk({tag, " rd_valid"}, {31'd0, rd_valid0}, {31'd0, vecs[i].e_vld});
            if (vecs[i].e_vld)
                chk({tag, " rd_data"}, rd_data0, vecs[i].e_rdata);
            chk({tag, " rd_valid outreg"}, {31'd0, rd_valid1}, {31'd0, prev_vld});
            if (prev_vld)
                chk({tag, " rd_data outreg"}, rd_data1, prev_data);
            prev_vld  = vecs[i].e_vld;
            prev_data = vecs[i].e_rdata;
        end

        // Reset asserted while the RMW write is being driven.
        @(negedge clk);
        drive(1'b1, 11'd5, 1'b0, '0, '0, 4'h0);
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 11'd12, 32'h000000EE, 4'h1);
        #1;
        chk("rst-rmw start mem_rd", {31'd0, m0_rd}, 32'd1);
        chk("rst-rmw start wr_ready", {31'd0, wr_ready0}, 32'd1);
        @(negedge clk);
        drive(1'b1, 11'd12, 1'b0, '0, '0, 4'h0);
        #1;
        chk("rst-rmw busy", {31'd0, busy0}, 32'd1);
        chk("rst-rmw mem_wr", {31'd0, m0_wr}, 32'd1);
        chk("rst-rmw mem_wr_data", m0_wr_data, 32'h121212EE);
        chk("rst-rmw rd_valid outreg", {31'd0, rd_valid1}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("in-reset busy", {31'd0, busy0}, 32'd0);
        chk("in-reset mem_wr", {31'd0, m0_wr}, 32'd0);
        chk("in-reset wr_ready", {31'd0, wr_ready0}, 32'd1);
        chk("in-reset rd_valid", {31'd0, rd_valid0}, 32'd0);
        chk("in-reset rd_valid outreg", {31'd0, rd_valid1}, 32'd0);
        chk("in-reset rd_data outreg", rd_data1, 32'd0);
        @(negedge clk);
        #1;
        chk("post-edge busy", {31'd0, busy0}, 32'd0);
        chk("post-edge mem_wr", {31'd0, m0_wr}, 32'd0);
        drive(1'b0, '0, 1'b0, '0, '0, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 11'd12, 1'b0, '0, '0, 4'h0);
        #1;
        chk("after-reset mem_wr", {31'd0, m0_wr}, 32'd0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0, '0, 4'h0);
        #1;
        chk("word12 rd_valid", {31'd0, rd_valid0}, 32'd1);
        chk("word12 rd_data", rd_data0, 32'h12121212);
        @(negedge clk);
        #1;
        chk("word12 rd_valid outreg", {31'd0, rd_valid1}, 32'd1);
        chk("word12 rd_data outreg", rd_data1, 32'h12121212);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
